// File: rtl/dac_i2s_tx.sv
// I2S transmitter for two signed 24-bit channels: BCK/LRCK generation, MSB-first
// serialisation with one-BCK delay, per-frame pop handshake and underrun flagging.
module dac_i2s_tx #(
    parameter int BCK_HALF = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] data_i,
    input  logic [1:0]  ack_i,
    output logic [1:0]  pop_o,
    output logic        bck_o,
    output logic        lrck_o,
    output logic        sdata_o,
    output logic        underrun_o
);

    localparam int                DIV_W    = $clog2(BCK_HALF);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCK_HALF - 1);

    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_bck;
    logic [5:0]        r_bit_cnt;
    logic              r_lrck;
    logic              r_sdata;
    logic [1:0]        r_pop;
    logic              r_underrun;
    logic [1:0][23:0]  r_hold;
    logic [1:0][23:0]  r_shift;
    logic [1:0]        r_valid;
    logic [1:0]        r_pending;

    logic              w_div_wrap;
    logic              w_fall;
    logic              w_frame;
    logic [5:0]        w_slot_nxt;
    logic              w_left;
    logic              w_right;
    logic              w_underrun;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_fall     = w_div_wrap & r_bck;
    assign w_frame    = w_fall & (r_bit_cnt == 6'd63);
    assign w_slot_nxt = r_bit_cnt + 6'd1;
    assign w_left     = (w_slot_nxt != 6'd0)  && (w_slot_nxt <= 6'd24);
    assign w_right    = (w_slot_nxt >= 6'd33) && (w_slot_nxt <= 6'd56);
    // An ack landing on the frame edge counts as answered, even though F still loads the old hold.
    assign w_underrun = |(r_pending & ~r_valid & ~ack_i);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bck     <= ~r_bck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
            r_shift   <= '0;
        end else if (w_fall) begin
            r_bit_cnt <= w_slot_nxt;
            r_lrck    <= w_slot_nxt[5];
            if (w_frame) begin
                r_shift <= r_hold;
                r_sdata <= 1'b0;
            end else if (w_left) begin
                r_sdata    <= r_shift[0][23];
                r_shift[0] <= {r_shift[0][22:0], 1'b0};
            end else if (w_right) begin
                r_sdata    <= r_shift[1][23];
                r_shift[1] <= {r_shift[1][22:0], 1'b0};
            end else begin
                r_sdata <= 1'b0;
            end
        end
    end

    // NOTE: the two holding registers are plain flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pop      <= 2'b00;
            r_underrun <= 1'b0;
            r_hold     <= '0;
            r_valid    <= 2'b00;
            r_pending  <= 2'b00;
        end else begin
            r_pop      <= w_frame ? 2'b11 : 2'b00;
            r_underrun <= w_frame & w_underrun;
            if (w_frame) begin
                r_pending <= 2'b11;
            end
            for (int n = 0; n < 2; n++) begin
                if (ack_i[n]) begin
                    r_hold[n]  <= data_i[24*n +: 24];
                    r_valid[n] <= 1'b1;
                end else if (w_frame) begin
                    r_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign pop_o      = r_pop;
    assign bck_o      = r_bck;
    assign lrck_o     = r_lrck;
    assign sdata_o    = r_sdata;
    assign underrun_o = r_underrun;

endmodule

// File: doc/dac_i2s_tx.md
DAC_I2S_TX -- requirements
Module: dac_i2s_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with no other clock or reset inputs.
REQ-002 Parameter BCK_HALF, default 16, SHALL set the number of clk cycles per half BCK period (integer, >= 2).
REQ-003 Port clk, input, 1 bit, SHALL be the system clock (98.304 MHz nominal).
REQ-004 Port rst, input, 1 bit, SHALL be the asynchronous active-low reset (0 = in reset).
REQ-005 Port data_i, input, 48 bits, SHALL carry signed 24-bit resampled samples: ch0 in [23:0], ch1 in [47:24].
REQ-006 Port ack_i, input, 2 bits, SHALL be per-channel write strobes, where bit n high for one clk means data_i for channel n is valid.
REQ-007 Port pop_o, output, 2 bits, SHALL be per-channel sample requests to the upstream resampler_core pop_i.
REQ-008 Ports bck_o, lrck_o and sdata_o, outputs, 1 bit each, SHALL be the I2S bit clock, word clock and serial data.
REQ-009 Port underrun_o, output, 1 bit, SHALL be a one-clk pulse indicating a missing sample at frame start.

Function
REQ-010 div_cnt SHALL count 0..BCK_HALF-1 and wrap, and bck_o SHALL toggle in the cycle div_cnt wraps.
REQ-011 A falling event (bck_o 1->0 toggle) SHALL advance bit_cnt (6 bits, 0..63, wraps 63->0); all of sdata_o, lrck_o and bit_cnt SHALL update on that same clk edge.
REQ-012 lrck_o SHALL equal the new bit_cnt[5]: slots 0-31 are left (lrck_o=0, ch0) and slots 32-63 are right (lrck_o=1, ch1).
REQ-013 The I2S format SHALL be MSB-first with a one-BCK delay: slot 1 carries bit 23 through slot 24 carrying bit 0 of ch0, and slot 33 carries bit 23 through slot 56 carrying bit 0 of ch1.
REQ-014 sdata_o SHALL be 0 in slots 0, 25-32 and 57-63.
REQ-015 Frame start F SHALL be the falling event where bit_cnt wraps 63->0, giving a frame of 128*BCK_HALF clk.
REQ-016 At F, the shift registers SHALL load from the holding registers hold[0] and hold[1].
REQ-017 At F, pop_o SHALL be registered to 2'b11 for exactly one clk and then return to 2'b00.
REQ-018 ack_i[n] SHALL write hold[n] from its slice of data_i and set valid[n]; ack_i without a pending request SHALL still be accepted.
REQ-019 At F, valid[n] SHALL clear, and pending[n] SHALL set when a pop is issued.
REQ-020 At F, if pending[n]=1 and valid[n]=0, underrun_o SHALL pulse for one clk and the shift register SHALL reload the stale hold[n], so the previous sample repeats.
REQ-021 If ack_i[n] coincides with F, F SHALL load the old hold[n], then the new value SHALL be written and valid[n] SHALL be set for the next frame, with no underrun.
REQ-022 Multiple ack_i[n] pulses within one frame SHALL make the last value win.
REQ-023 Sample data SHALL be passed bit-exact, with no arithmetic, saturation or sign change.

Reset
REQ-024 While rst=0, the following SHALL be 0: bck_o, lrck_o, sdata_o, pop_o, underrun_o, div_cnt, bit_cnt, hold, shift registers, valid and pending.
REQ-025 Assertion of rst mid-frame SHALL force REQ-024 values immediately (asynchronously), with no pop_o or underrun_o glitch.
REQ-026 After rst releases, the first pop_o SHALL occur at the first F (64 BCK later), the first two frames SHALL output zeros, and no underrun SHALL be flagged at that first F.

Verification
REQ-027 Scenario: BCK_HALF=2, reset then free-run -> bck_o period 4 clk, lrck_o period 256 clk, and pop_o=2'b11 for one clk every 256 clk.
REQ-028 Scenario: after pop, ack_i=2'b01 with data 24'h800001, and ack_i=2'b10 with data 24'h7FFFFE -> next frame slots 1-24 serialise 1000...0001 and slots 33-56 serialise 0111...1110, with zeros elsewhere.
REQ-029 Scenario: answer pop with ch0 only -> at next F underrun_o pulses once and ch1 repeats its previous sample.
REQ-030 Scenario: ack_i[0] in the same clk as F -> the frame carries the old ch0, the following frame carries the new value, and underrun_o stays 0.
REQ-031 Scenario: drive rst=0 at bit_cnt=40 mid-sample -> all outputs 0 within the same cycle, and after release the first pop_o arrives 256 clk later.
REQ-032 Scenario: drive upstream resampler_core with a ramp -> the decoded sdata_o words match the accepted ack_i data in order, with no drops.
